// File: rtl/arm_pkg.sv
// Shared types and constants for the ARM decode/control slice.
package arm_pkg;

  // Four-phase instruction lifecycle
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_DECODE = 2'b01,
    ST_EXEC   = 2'b10,
    ST_WB     = 2'b11
  } state_e;

  // ALU command class field
  localparam logic [1:0] CLS_DP  = 2'b00;
  localparam logic [1:0] CLS_MUL = 2'b11;

  // ALU opcodes understood by the combinational ALU
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_EOR = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_RSB = 4'b0011;
  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_ADC = 4'b0101;
  localparam logic [3:0] ALU_ORR = 4'b1100;
  localparam logic [3:0] ALU_BIC = 4'b1110;
  localparam logic [3:0] ALU_MVN = 4'b1111;

  // Architectural data-processing opcodes, instr[24:21]
  typedef enum logic [3:0] {
    DP_AND, DP_EOR, DP_SUB, DP_RSB, DP_ADD, DP_ADC, DP_SBC, DP_RSC,
    DP_TST, DP_TEQ, DP_CMP, DP_CMN, DP_ORR, DP_MOV, DP_BIC, DP_MVN
  } dp_op_e;

  // Condition field, instr[31:28]; NV marks the undefined encoding
  typedef enum logic [3:0] {
    COND_EQ, COND_NE, COND_CS, COND_CC, COND_MI, COND_PL, COND_VS, COND_VC,
    COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_AL, COND_NV
  } cond_e;

  // Rotate an 8-bit immediate right by twice the 4-bit rotate field
  function automatic logic [31:0] rot_imm(input logic [7:0] imm8, input logic [3:0] rot);
    logic [63:0] dbl;
    dbl = {24'h0, imm8, 24'h0, imm8} >> {rot, 1'b0};
    return dbl[31:0];
  endfunction

  // Arithmetic ALU ops also produce a meaningful carry
  function automatic logic is_arith(input logic [3:0] alu_op);
    return (alu_op == ALU_SUB) || (alu_op == ALU_RSB) ||
           (alu_op == ALU_ADD) || (alu_op == ALU_ADC);
  endfunction

endpackage

// File: rtl/cond_check.sv
// Evaluates an ARM condition field against the NZCV flags.
module cond_check
  import arm_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass,
  output logic       undef
);

  logic n, z, c, v;
  assign {n, z, c, v} = nzcv;

  // Condition truth table; the 1111 encoding never passes and is flagged undefined
  always_comb begin
    pass  = 1'b0;
    undef = 1'b0;
    case (cond_e'(cond))
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: undef = 1'b1;
    endcase
  end

endmodule

// File: rtl/arm_decode_ctrl.sv
// Multi-cycle ARM decode/control unit: decodes one instruction, issues the
// ALU command, then commits flags and the register write-enable.
module arm_decode_ctrl
  import arm_pkg::*;
#(
  parameter bit SUPPORT_MUL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [7:0]  ctrl_cmd,
  output logic [3:0]  rn_addr,
  output logic [3:0]  rm_addr,
  output logic [3:0]  rd_addr,
  output logic [31:0] imm_ext,
  output logic        src2_imm,
  output logic        src1_zero,
  output logic        alu_valid,
  input  logic [3:0]  new_flags,
  output logic [3:0]  current_flags,
  output logic        reg_we,
  output logic        undef
);

  state_e      state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [3:0]  rn_q, rn_d, rm_q, rm_d, rd_q, rd_d;
  logic [31:0] imm_q, imm_d;
  logic        src2_imm_q, src2_imm_d;
  logic        src1_zero_q, src1_zero_d;
  logic        pass_q;
  logic        undef_q, undef_d;
  logic        no_wb_q, no_wb_d;
  logic [3:0]  flags_q, flags_d;

  logic        handshake;
  logic        cond_pass, cond_undef, dec_undef;
  logic [1:0]  cls;
  logic [3:0]  alu_op;
  logic        s_bit;
  logic        v_unused;

  // The ALU's V output is never committed
  assign v_unused  = new_flags[0];
  assign handshake = instr_valid & instr_ready;

  // Condition is judged against the flags committed by the previous instruction
  cond_check u_cond (
    .cond  (instr[31:28]),
    .nzcv  (flags_q),
    .pass  (cond_pass),
    .undef (cond_undef)
  );

  // Decode the incoming word; multiply must be recognised before data processing
  always_comb begin
    cls         = CLS_DP;
    alu_op      = ALU_AND;
    s_bit       = instr[20];
    dec_undef   = 1'b0;
    rn_d        = instr[19:16];
    rm_d        = instr[3:0];
    rd_d        = instr[15:12];
    imm_d       = '0;
    src2_imm_d  = 1'b0;
    src1_zero_d = 1'b0;
    no_wb_d     = 1'b0;
    if (instr[27:22] == 6'b000000 && instr[7:4] == 4'b1001) begin
      cls  = CLS_MUL;
      rd_d = instr[19:16];
      rn_d = instr[11:8];
      if (!SUPPORT_MUL) dec_undef = 1'b1;
    end else if (instr[27:26] == 2'b00) begin
      src2_imm_d = instr[25];
      if (instr[25]) imm_d = rot_imm(instr[7:0], instr[11:8]);
      else if (instr[11:4] != 8'h00) dec_undef = 1'b1;
      case (dp_op_e'(instr[24:21]))
        DP_AND, DP_EOR, DP_SUB, DP_RSB, DP_ADD,
        DP_ADC, DP_ORR, DP_BIC, DP_MVN: alu_op = instr[24:21];
        DP_TST: begin alu_op = ALU_AND; s_bit = 1'b1; no_wb_d = 1'b1; end
        DP_TEQ: begin alu_op = ALU_EOR; s_bit = 1'b1; no_wb_d = 1'b1; end
        DP_CMP: begin alu_op = ALU_SUB; s_bit = 1'b1; no_wb_d = 1'b1; end
        DP_CMN: begin alu_op = ALU_ADD; s_bit = 1'b1; no_wb_d = 1'b1; end
        DP_MOV: begin alu_op = ALU_ORR; src1_zero_d = 1'b1; end
        default: dec_undef = 1'b1;
      endcase
    end else begin
      dec_undef = 1'b1;
    end
    cmd_d   = {cls, instr[25], alu_op, s_bit};
    undef_d = dec_undef | cond_undef;
  end

  // Latch decode results at the accepting edge so they are stable through WB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q       <= '0;
      rn_q        <= '0;
      rm_q        <= '0;
      rd_q        <= '0;
      imm_q       <= '0;
      src2_imm_q  <= 1'b0;
      src1_zero_q <= 1'b0;
      pass_q      <= 1'b0;
      undef_q     <= 1'b0;
      no_wb_q     <= 1'b0;
    end else if (handshake) begin
      cmd_q       <= cmd_d;
      rn_q        <= rn_d;
      rm_q        <= rm_d;
      rd_q        <= rd_d;
      imm_q       <= imm_d;
      src2_imm_q  <= src2_imm_d;
      src1_zero_q <= src1_zero_d;
      pass_q      <= cond_pass;
      undef_q     <= undef_d;
      no_wb_q     <= no_wb_d;
    end
  end

  // Flag commit at the end of EXEC; carry only from arithmetic ops, V held
  always_comb begin
    flags_d = flags_q;
    if (state_q == ST_EXEC && pass_q && !undef_q && cmd_q[0]) begin
      flags_d[3:2] = new_flags[3:2];
      if (cmd_q[7:6] == CLS_DP && is_arith(cmd_q[4:1])) flags_d[1] = new_flags[1];
    end
  end

  // State and flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

  // Fixed walk through the four phases, waiting in IDLE for a handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (handshake) state_d = ST_DECODE;
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC:   state_d = ST_WB;
      ST_WB:     state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign instr_ready   = (state_q == ST_IDLE);
  assign alu_valid     = (state_q == ST_EXEC) & pass_q & ~undef_q;
  assign reg_we        = (state_q == ST_WB) & pass_q & ~undef_q & ~no_wb_q;
  assign undef         = (state_q == ST_WB) & undef_q;
  assign ctrl_cmd      = cmd_q;
  assign rn_addr       = rn_q;
  assign rm_addr       = rm_q;
  assign rd_addr       = rd_q;
  assign imm_ext       = imm_q;
  assign src2_imm      = src2_imm_q;
  assign src1_zero     = src1_zero_q;
  assign current_flags = flags_q;

endmodule
